legv8_instr_encoder: RTL and testbench
======================================

Name: legv8_instr_encoder

Overview:
- Inverse of the decode stage: takes LEGv8 instruction fields (format, opcode, register numbers, immediate) and produces the 32-bit instruction word.
- Fits each word with a sequential instruction-memory address and streams it to an imem write port or a bench through a small output FIFO.
- Used to build test programs for the fetch/decode/execute integration benches without hand-computing hex words.

Parameters:
- DEPTH, 2, output FIFO entries (power of 2, >=2)
- ADDR_BASE, 0, byte address of the first emitted word
- MEM_WORDS, 16, instruction memory size in words; the address wraps after MEM_WORDS words

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_fmt  in  3  0=R, 1=I, 2=D, 3=B, 4=CB; other values are illegal
- in_opcode  in  11  left-justified opcode: R/D use [10:0], I uses [10:1], CB uses [10:3], B uses [10:5]
- in_rd  in  5  Rd/Rt
- in_rn  in  5  Rn
- in_rm  in  5  Rm
- in_shamt  in  6  R-format shamt
- in_imm  in  26  signed immediate (two's complement)
- restart  in  1  synchronous: address counter returns to ADDR_BASE
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts the head
- out_instr  out  32  encoded word
- out_addr  out  64  byte address of out_instr
- out_err  out  1  head word had an encoding error
- err_count  out  8  saturating count of errored words accepted

Behaviour:
- Reset (async, active-high) clears the FIFO and all flags:
  - out_valid=0, out_instr=0, out_err=0, out_addr=ADDR_BASE, err_count=0.
  - in_ready=1 on the first cycle after reset deasserts.
- Input handshake: a bundle is accepted on a rising clk edge when in_valid && in_ready.
  - in_ready = FIFO not full. It does not depend on out_ready in the same cycle, so a full FIFO refuses input even while it is popping.
- Encoding is combinational from the inputs and is written into the FIFO at the accept edge:
  - R: {op[10:0], rm, shamt, rn, rd}
  - I: {op[10:1], imm[11:0], rn, rd}
  - D: {op[10:0], imm[8:0], 2'b00, rn, rd}
  - B: {op[10:5], imm[25:0]}
  - CB: {op[10:3], imm[18:0], rd}
- Range check on the immediate:
  - I: imm must lie in 0..4095 (unsigned).
  - D: imm must fit a signed 9-bit field; CB: signed 19-bit; B: always legal.
  - On violation, the word is still emitted with the immediate truncated, and out_err=1 travels with it.
- Illegal in_fmt: word=0, err=1.
- Latency: a word accepted at edge N is visible at out_* after edge N when the FIFO was empty (1 cycle). FIFO order is preserved.
- Output handshake: the head pops when out_valid && out_ready.
  - out_instr, out_addr and out_err are stable while out_valid && !out_ready.
  - When out_valid=0, out_* hold their last values.
- Address:
  - Assigned at accept time as ADDR_BASE + 4*k, stored in the FIFO entry.
  - k increments on each accept and wraps to 0 after MEM_WORDS-1.
  - restart forces k=0 for the next accept; entries already in the FIFO keep their addresses.
  - If restart and an accept occur in the same cycle, the accepted word takes ADDR_BASE and the next word gets ADDR_BASE+4.
- err_count increments on accept of an errored word and saturates at 255.
- Push and pop in the same cycle (FIFO not full): the occupancy count is unchanged.
- Reset mid-stream drops all queued words with no partial output.

Test Plan:
- Basic encodes, one per bundle, out_ready=1:
  - D LDUR (op 11111000010, rd=9, rn=22, imm=64) -> 0xF84402C9 at addr 0.
  - R ADD (op 10001011000, rd=10, rn=19, rm=9) -> 0x8B09026A at addr 4.
  - R SUB (rd=11, rn=20, rm=10) -> 0xCB0A028B at addr 8.
  - D STUR (op 11111000000, rd=11, rn=22, imm=96) -> 0xF80602CB at addr 12.
  - Every word has out_err=0.
- Branch formats:
  - CB CBZ (op 10110100xxx, rd=11, imm=-5) -> 0xB4FFFF6B.
  - B (op 000101xxxxx, imm=64) -> 0x14000040.
  - B (imm=-55) -> 0x17FFFFC9.
- Backpressure: hold out_ready=0 and push 3 bundles.
  - in_ready drops after 2 accepts; the third bundle waits.
  - The head holds 0xF84402C9 stable.
  - Release out_ready -> the words drain in order, and the third is accepted the cycle after the first pop.
- Range and illegal-format errors:
  - D with imm=300 -> out_err=1, word carries imm[8:0]=0x12C, err_count=1.
  - in_fmt=7 -> word 0, out_err=1, err_count=2.
- Address wrap and restart:
  - With MEM_WORDS=16, 17 accepts give the 17th word addr 0.
  - restart asserted together with an accept -> that word has addr 0 and the next has addr 4.
- Async reset with 2 words queued: assert reset between edges.
  - out_valid=0 and err_count=0 immediately.
  - Next word accepted after release gets addr ADDR_BASE.

Source files
------------

// File: rtl/legv8_instr_encoder.sv
// LEGv8 instruction encoder: packs field bundles into 32-bit words, tags each with
// a sequential imem byte address and an encoding-error flag, and queues them in a small FIFO.
module legv8_instr_encoder #(
  parameter int          DEPTH     = 2,
  parameter logic [63:0] ADDR_BASE = 64'd0,
  parameter int          MEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [10:0] in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rn,
  input  logic [4:0]  in_rm,
  input  logic [5:0]  in_shamt,
  input  logic [25:0] in_imm,
  input  logic        restart,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_addr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int KW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(MEM_WORDS - 1);
  localparam logic [PW:0]   FULL   = (PW + 1)'(DEPTH);

  logic [31:0] word_next;
  logic        err_next;
  logic [63:0] addr_next;
  logic [KW-1:0] k_reg;
  logic [KW-1:0] k_acc;
  logic [PW:0]   count_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [31:0] last_instr_reg;
  logic [63:0] last_addr_reg;
  logic        last_err_reg;
  logic [7:0]  err_count_reg;
  logic        accept;
  logic        pop;

  logic [31:0] instr_mem [DEPTH];
  logic [63:0] addr_mem  [DEPTH];
  logic        err_mem   [DEPTH];

  // Out-of-range immediates are still packed (truncated) but flagged.
  always_comb begin
    word_next = '0;
    err_next  = 1'b0;
    case (in_fmt)
      3'd0: word_next = {in_opcode, in_rm, in_shamt, in_rn, in_rd};
      3'd1: begin
        word_next = {in_opcode[10:1], in_imm[11:0], in_rn, in_rd};
        err_next  = |in_imm[25:12];
      end
      3'd2: begin
        word_next = {in_opcode, in_imm[8:0], 2'b00, in_rn, in_rd};
        err_next  = !((&in_imm[25:8]) || !(|in_imm[25:8]));
      end
      3'd3: word_next = {in_opcode[10:5], in_imm};
      3'd4: begin
        word_next = {in_opcode[10:3], in_imm[18:0], in_rd};
        err_next  = !((&in_imm[25:18]) || !(|in_imm[25:18]));
      end
      default: begin
        word_next = '0;
        err_next  = 1'b1;
      end
    endcase
  end

  assign in_ready  = (count_reg != FULL);
  assign out_valid = (count_reg != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // A restart in the accept cycle already applies to the word being accepted.
  assign k_acc     = restart ? '0 : k_reg;
  assign addr_next = ADDR_BASE + (64'(k_acc) << 2);

  always_ff @(posedge clk) begin
    if (accept) begin
      instr_mem[wr_ptr_reg] <= word_next;
      addr_mem[wr_ptr_reg]  <= addr_next;
      err_mem[wr_ptr_reg]   <= err_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_reg          <= '0;
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      last_instr_reg <= '0;
      last_addr_reg  <= ADDR_BASE;
      last_err_reg   <= 1'b0;
      err_count_reg  <= '0;
    end else begin
      if (accept) begin
        k_reg      <= (k_acc == K_LAST) ? '0 : k_acc + 1'b1;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (err_next && err_count_reg != 8'hFF)
          err_count_reg <= err_count_reg + 8'd1;
      end else if (restart) begin
        k_reg <= '0;
      end
      if (pop) begin
        rd_ptr_reg     <= rd_ptr_reg + 1'b1;
        last_instr_reg <= instr_mem[rd_ptr_reg];
        last_addr_reg  <= addr_mem[rd_ptr_reg];
        last_err_reg   <= err_mem[rd_ptr_reg];
      end
      case ({accept, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // With the FIFO empty the outputs keep showing the most recently popped word.
  assign out_instr = out_valid ? instr_mem[rd_ptr_reg] : last_instr_reg;
  assign out_addr  = out_valid ? addr_mem[rd_ptr_reg]  : last_addr_reg;
  assign out_err   = out_valid ? err_mem[rd_ptr_reg]   : last_err_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Self-checking bench for legv8_instr_encoder: fixed encode table, backpressure,
// address wrap/restart and async-reset sequences, then random traffic vs a scoreboard.
module tb_legv8_instr_encoder;

  localparam int          DEPTH     = 2;
  localparam logic [63:0] ADDR_BASE = 64'h0;
  localparam int          MEM_WORDS = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [10:0] in_opcode;
  logic [4:0]  in_rd, in_rn, in_rm;
  logic [5:0]  in_shamt;
  logic [25:0] in_imm;
  logic        restart;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  legv8_instr_encoder #(.DEPTH(DEPTH), .ADDR_BASE(ADDR_BASE), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
    .in_shamt(in_shamt), .in_imm(in_imm), .restart(restart),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [10:0] op;
    logic [4:0]  rd, rn, rm;
    logic [5:0]  shamt;
    logic [25:0] imm;
    logic [31:0] word;
    logic        err;
    int          errc;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        err;
  } ent_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t q[$];
  ent_t last;
  int   k_model;
  int   errc_model;
  bit   acc_seen, pop_seen;
  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference encoding computed arithmetically from field weights and value ranges.
  function automatic void ref_encode(input logic [2:0] fmt, input logic [10:0] op,
                                     input logic [4:0] rd, input logic [4:0] rn,
                                     input logic [4:0] rm, input logic [5:0] shamt,
                                     input logic [25:0] imm,
                                     output logic [31:0] w, output logic e);
    longint v, acc, o, r_d, r_n, r_m, sh;
    v   = longint'($signed(imm));
    o   = longint'(op);
    r_d = longint'(rd);
    r_n = longint'(rn);
    r_m = longint'(rm);
    sh  = longint'(shamt);
    acc = 0;
    e   = 1'b0;
    case (fmt)
      3'd0: acc = o * (1 << 21) + r_m * (1 << 16) + sh * (1 << 10) + r_n * 32 + r_d;
      3'd1: begin
        acc = (o / 2) * (1 << 22) + (v & 4095) * (1 << 10) + r_n * 32 + r_d;
        e   = (v < 0) || (v > 4095);
      end
      3'd2: begin
        acc = o * (1 << 21) + (v & 511) * (1 << 12) + r_n * 32 + r_d;
        e   = (v < -256) || (v > 255);
      end
      3'd3: acc = (o / 32) * (1 << 26) + (v & ((1 << 26) - 1));
      3'd4: begin
        acc = (o / 8) * (1 << 24) + (v & ((1 << 19) - 1)) * 32 + r_d;
        e   = (v < -(1 << 18)) || (v >= (1 << 18));
      end
      default: begin
        acc = 0;
        e   = 1'b1;
      end
    endcase
    w = acc[31:0];
  endfunction

  task automatic model_reset();
    q.delete();
    k_model    = 0;
    errc_model = 0;
    last       = '{instr: 32'h0, addr: ADDR_BASE, err: 1'b0};
  endtask

  task automatic set_bundle(input vec_t v);
    in_fmt    = v.fmt;
    in_opcode = v.op;
    in_rd     = v.rd;
    in_rn     = v.rn;
    in_rm     = v.rm;
    in_shamt  = v.shamt;
    in_imm    = v.imm;
  endtask

  task automatic rand_bundle();
    in_fmt    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    in_opcode = 11'($urandom);
    in_rd     = 5'($urandom);
    in_rn     = 5'($urandom);
    in_rm     = 5'($urandom);
    in_shamt  = 6'($urandom);
    case ($urandom_range(0, 2))
      0:       in_imm = 26'($urandom_range(0, 600));
      1:       in_imm = 26'(-$urandom_range(0, 600));
      default: in_imm = 26'($urandom);
    endcase
  endtask

  // One clock: sample handshake mid-cycle, advance model, then check all outputs.
  task automatic cycle();
    logic        acc, pop, rs;
    logic [31:0] w;
    logic        e;
    int          kk;
    ent_t        ent;
    ent_t        exp_head;
    w = '0;
    e = 1'b0;
    @(negedge clk);
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    rs  = restart;
    if (acc) ref_encode(in_fmt, in_opcode, in_rd, in_rn, in_rm, in_shamt, in_imm, w, e);
    @(posedge clk);
    #1;
    if (pop && q.size() > 0) last = q.pop_front();
    if (acc) begin
      kk        = rs ? 0 : k_model;
      ent.instr = w;
      ent.err   = e;
      ent.addr  = ADDR_BASE + 64'(4 * kk);
      k_model   = (kk + 1) % MEM_WORDS;
      q.push_back(ent);
      if (e && errc_model < 255) errc_model++;
    end else if (rs) begin
      k_model = 0;
    end
    acc_seen = acc;
    pop_seen = pop;
    exp_head = (q.size() > 0) ? q[0] : last;
    check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("out_instr", 64'(out_instr), 64'(exp_head.instr));
    check("out_addr", out_addr, exp_head.addr);
    check("out_err", 64'(out_err), 64'(exp_head.err));
    check("err_count", 64'(err_count), 64'(errc_model));
  endtask

  initial begin
    tbl[0] = '{3'd2, 11'b11111000010, 5'd9,  5'd22, 5'd0,  6'd0, 26'd64,  32'hF84402C9, 1'b0, 0};
    tbl[1] = '{3'd0, 11'b10001011000, 5'd10, 5'd19, 5'd9,  6'd0, 26'd0,   32'h8B09026A, 1'b0, 0};
    tbl[2] = '{3'd0, 11'b11001011000, 5'd11, 5'd20, 5'd10, 6'd0, 26'd0,   32'hCB0A028B, 1'b0, 0};
    tbl[3] = '{3'd2, 11'b11111000000, 5'd11, 5'd22, 5'd0,  6'd0, 26'd96,  32'hF80602CB, 1'b0, 0};
    tbl[4] = '{3'd4, 11'b10110100000, 5'd11, 5'd0,  5'd0,  6'd0, -26'sd5, 32'hB4FFFF6B, 1'b0, 0};
    tbl[5] = '{3'd3, 11'b00010100000, 5'd0,  5'd0,  5'd0,  6'd0, 26'd64,  32'h14000040, 1'b0, 0};
    tbl[6] = '{3'd3, 11'b00010100000, 5'd0,  5'd0,  5'd0,  6'd0, -26'sd55, 32'h17FFFFC9, 1'b0, 0};
    tbl[7] = '{3'd2, 11'b11111000010, 5'd9,  5'd22, 5'd0,  6'd0, 26'd300, 32'hF852C2C9, 1'b1, 1};
    tbl[8] = '{3'd7, 11'b11111000010, 5'd9,  5'd22, 5'd0,  6'd0, 26'd1,   32'h00000000, 1'b1, 2};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; restart = 1'b0;
    set_bundle(tbl[0]);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_addr", out_addr, ADDR_BASE);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Table of single encodes with one-cycle latency.
    for (int i = 0; i < 9; i++) begin
      set_bundle(tbl[i]);
      in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      check("tbl_accept", 64'(acc_seen), 64'd1);
      check("tbl_word", 64'(out_instr), 64'(tbl[i].word));
      check("tbl_err", 64'(out_err), 64'(tbl[i].err));
      check("tbl_addr", out_addr, ADDR_BASE + 64'(4 * i));
      check("tbl_errc", 64'(err_count), 64'(tbl[i].errc));
      cycle();
    end

    // Backpressure: two fill the FIFO, third waits until the cycle after the first pop.
    out_ready = 1'b0; in_valid = 1'b1;
    set_bundle(tbl[0]); cycle();
    set_bundle(tbl[1]); cycle();
    check("bp_full", 64'(in_ready), 64'd0);
    set_bundle(tbl[2]); cycle();
    check("bp_wait", 64'(acc_seen), 64'd0);
    check("bp_head", 64'(out_instr), 64'hF84402C9);
    cycle();
    check("bp_head_hold", 64'(out_instr), 64'hF84402C9);
    out_ready = 1'b1;
    cycle();
    check("bp_pop", 64'(pop_seen), 64'd1);
    check("bp_no_acc_on_pop", 64'(acc_seen), 64'd0);
    cycle();
    check("bp_third_acc", 64'(acc_seen), 64'd1);
    in_valid = 1'b0;
    repeat (3) cycle();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Address wrap after MEM_WORDS accepts, then restart coinciding with an accept.
    restart = 1'b1; cycle(); restart = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rand_bundle();
      in_fmt = 3'd0;
      cycle();
    end
    check("wrap_addr", out_addr, ADDR_BASE);
    restart = 1'b1; rand_bundle(); cycle(); restart = 1'b0;
    check("restart_addr", out_addr, ADDR_BASE);
    rand_bundle(); cycle();
    check("restart_next_addr", out_addr, ADDR_BASE + 64'd4);
    in_valid = 1'b0;
    repeat (2) cycle();

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      rand_bundle();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      restart   = ($urandom_range(0, 19) == 0);
      cycle();
    end
    restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    // Async reset between edges with two words queued, one of them errored.
    out_ready = 1'b0; in_valid = 1'b1;
    set_bundle(tbl[1]); cycle();
    set_bundle(tbl[8]); cycle();
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_err_count", 64'(err_count), 64'd0);
    check("arst_out_instr", 64'(out_instr), 64'd0);
    model_reset();
    reset = 1'b0;
    set_bundle(tbl[2]); in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("post_rst_addr", out_addr, ADDR_BASE);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    repeat (2) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
